branch_outcome_tracker: RTL

BRANCH_OUTCOME_TRACKER -- requirements
Module: branch_outcome_tracker

---
 rtl/br_pred_pkg.sv | 16 +
 rtl/br_track_fifo.sv | 77 +++++++
 rtl/branch_outcome_tracker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/br_pred_pkg.sv
// Shared types and constants for the branch outcome tracker.
package br_pred_pkg;

  localparam int unsigned PC_W          = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned STAT_W        = 16;

  // Fall-through PC after a not-taken branch skips the delay slot.
  localparam logic [PC_W-1:0] DELAY_SLOT_OFFSET = PC_W'(8);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pre_taken;
  } br_track_entry_t;

endpackage

// File: rtl/br_track_fifo.sv
// In-order FIFO of predicted branches with wrap-around pointers and a clear
// that overrides push/pop.
module br_track_fifo
  import br_pred_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  br_track_entry_t          wdata,
  input  logic                     pop,
  output br_track_entry_t          rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  br_track_entry_t mem_q [DEPTH];
  br_track_entry_t mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_outcome_tracker.sv
// Tracks in-flight predicted branches, compares resolutions against predictions
// and drives predictor training and fetch redirect. Optional stats: BR_TRACK_STATS_EN.
module branch_outcome_tracker
  import br_pred_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  input  logic [PC_W-1:0]        alloc_pc,
  input  logic                   alloc_pre_taken,
  output logic                   alloc_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [PC_W-1:0]        res_target,
  output logic                   res_ready,
  input  logic                   flush,
  output logic                   update_en,
  output logic [PC_W-1:0]        pc_update,
  output logic                   real_br_taken,
  output logic                   mispredict,
  output logic [PC_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] count
`ifdef BR_TRACK_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_resolved,
  output logic [STAT_W-1:0]      stat_mispredict
`endif
);

  br_track_entry_t head;
  br_track_entry_t wentry;
  logic            fifo_full, fifo_empty;
  logic            accept_res, accept_alloc, mis_c, clr_c;

  logic            update_en_q, update_en_d;
  logic [PC_W-1:0] pc_update_q, pc_update_d;
  logic            real_br_taken_q, real_br_taken_d;
  logic            mispredict_q, mispredict_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;

  assign alloc_ready = !fifo_full;
  assign res_ready   = !fifo_empty;

  // Flush wins over everything; a mispredict squashes the same-cycle allocation.
  always_comb begin
    accept_res   = res_valid && !fifo_empty && !flush;
    mis_c        = accept_res && (res_taken != head.pre_taken);
    clr_c        = flush || mis_c;
    accept_alloc = alloc_valid && (!fifo_full || accept_res) && !clr_c;
    wentry.pc        = alloc_pc;
    wentry.pre_taken = alloc_pre_taken;
  end

  br_track_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_c),
    .push  (accept_alloc),
    .wdata (wentry),
    .pop   (accept_res),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    update_en_d     = accept_res;
    pc_update_d     = pc_update_q;
    real_br_taken_d = real_br_taken_q;
    mispredict_d    = mis_c;
    redirect_pc_d   = redirect_pc_q;
    if (accept_res) begin
      pc_update_d     = head.pc;
      real_br_taken_d = res_taken;
    end
    if (mis_c) begin
      redirect_pc_d = res_taken ? res_target : (head.pc + DELAY_SLOT_OFFSET);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_en_q     <= 1'b0;
      pc_update_q     <= '0;
      real_br_taken_q <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
    end else begin
      update_en_q     <= update_en_d;
      pc_update_q     <= pc_update_d;
      real_br_taken_q <= real_br_taken_d;
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  assign update_en     = update_en_q;
  assign pc_update     = pc_update_q;
  assign real_br_taken = real_br_taken_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;

`ifdef BR_TRACK_STATS_EN
  logic [STAT_W-1:0] stat_resolved_q, stat_resolved_d;
  logic [STAT_W-1:0] stat_mispredict_q, stat_mispredict_d;

  // Saturating event counters.
  always_comb begin
    stat_resolved_d   = stat_resolved_q;
    stat_mispredict_d = stat_mispredict_q;
    if (accept_res && (stat_resolved_q != '1)) begin
      stat_resolved_d = stat_resolved_q + STAT_W'(1);
    end
    if (mis_c && (stat_mispredict_q != '1)) begin
      stat_mispredict_d = stat_mispredict_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign stat_resolved   = stat_resolved_q;
  assign stat_mispredict = stat_mispredict_q;
`endif

endmodule
